reset_sequencer: RTL
====================

# reset_sequencer

Consumes the locked clock and synchronized system reset from the clock unit and releases per-subsystem resets in a fixed order on clk_sys. Each stage is released only after the previous stage has reported ready. Ready timeouts cause bounded retries and then a latched fault. It sits between the clock unit and the MIG, GT and user-logic reset inputs.

## Interface
- NUM_STAGES, 3: number of ordered reset stages, 1..8.
- RELEASE_DLY, 256: cycles of reset hold before each stage release, ≥1.
- TIMEOUT, 1048576: cycles allowed per stage for stage_ready after its release, ≥2.
- RETRY_MAX, 3: timeouts tolerated before fault, ≥0.

Ports:
- clk_sys, in, 1: the only clock.
- rst_sys_n, in, 1: synchronous, active-low reset.
- pll_locked, in, 1: MMCM lock, already synchronous to clk_sys.
- stage_ready, in, NUM_STAGES: per-stage done flag (MIG calib, GT reset done, …), synchronous to clk_sys.
- soft_rst, in, 1: one-cycle restart request; also clears fault.
- stage_rst, out, NUM_STAGES: active-high per-stage resets, registered.
- all_ready, out, 1: high in RUN only.
- fault, out, 1: high in FAULT only.
- retry_cnt, out, $clog2(RETRY_MAX+1) (minimum 1 bit): timeouts since last RUN.
- state_dbg, out, 3: encoded FSM state.

## Operation
- States: IDLE, HOLD, WAIT, RUN, FAULT.
  - stage index k is 0..NUM_STAGES-1.
  - cnt is a down-counter; tmo is the timeout counter.
- IDLE:
  - stage_rst all ones.
  - pll_locked=1 → HOLD with k=0 and cnt=RELEASE_DLY-1.
- HOLD:
  - stage_rst[j]=1 for j≥k; stages j<k stay released.
  - cnt=0 → WAIT, with stage_rst[k] cleared on that same edge and tmo=TIMEOUT-1.
- WAIT:
  - stage_ready[k]=1 and k<NUM_STAGES-1 → HOLD with k+1 and cnt reloaded.
  - stage_ready[k]=1 and k=NUM_STAGES-1 → RUN; retry_cnt clears to 0.
  - tmo=0 without ready:
    - retry_cnt<RETRY_MAX → retry_cnt+1, then HOLD with k=0 and all stage_rst=1.
    - otherwise → FAULT.
  - stage_ready[j]=0 for any j<k counts as a timeout.
- RUN:
  - all_ready=1.
  - Any stage_ready bit falls → HOLD with k=0 and all resets reasserted; retry_cnt unchanged.
- FAULT:
  - All stage_rst=1; fault=1.
  - Exits only on soft_rst or rst_sys_n.
- Priority, highest first: rst_sys_n=0, then pll_locked=0, then soft_rst, then ready, then timeout.
- pll_locked=0 in any state → IDLE next cycle, with all stage_rst=1 on that edge.
- soft_rst=1 in any state other than IDLE → HOLD with k=0; retry_cnt=0 and fault=0.
- soft_rst in IDLE is ignored.
- Ready and timeout in the same cycle: ready wins.
- Counters saturate at 0 and never wrap. retry_cnt never exceeds RETRY_MAX.

## Timing
- Reset values:
  - stage_rst all ones.
  - all_ready=0, fault=0, retry_cnt=0.
  - state_dbg=IDLE (0).
- stage_rst[0] falls exactly RELEASE_DLY+1 cycles after the first cycle pll_locked is sampled high: 1 cycle for IDLE→HOLD plus RELEASE_DLY cycles of HOLD.
- Stage k+1 is released exactly RELEASE_DLY cycles after the edge on which stage_ready[k] is sampled high.
- all_ready rises 1 cycle after stage_ready[NUM_STAGES-1] is sampled high.
- Timeout: WAIT lasts at most TIMEOUT cycles. The stage_rst reassert occurs on the edge after the TIMEOUT-th WAIT cycle.
- Loss of lock, or a ready bit dropping in RUN, reaches stage_rst after 1 edge. No combinational paths from inputs to outputs.
- State encoding on state_dbg: IDLE=0, HOLD=1, WAIT=2, RUN=3, FAULT=4.

## Structure
- Shared package reset_sequencer_pkg:
  - state enum reset_seq_state_t, 3-bit, with the encodings above.
  - width helper constants.
- One sub-module, reset_seq_timer:
  - loadable saturating down-counter with load value, load strobe, enable, and zero flag.
  - instantiated twice: hold delay (cnt) and stage timeout (tmo).
- Stage index and retry counter stay in the top FSM.

## Test plan
Parameters: NUM_STAGES=3, RELEASE_DLY=4, TIMEOUT=16, RETRY_MAX=2.

- Nominal bring-up:
  - Stimulus: lock high at cycle 10; stage_ready[k] raised 3 cycles after each release.
  - Required: stage_rst goes 111→110 at cycle 15, 110→100 at 22, 100→000 at 29; all_ready=1 at 33.
- Timeout and retries:
  - Stimulus: stage_ready[1] never asserted.
  - Required: two restarts with retry_cnt incrementing 1 then 2; after the third timeout, FAULT with stage_rst=111 and fault=1. soft_rst then clears fault and retry_cnt and enters HOLD.
- Lock loss mid-WAIT of stage 2:
  - Required: stage_rst=111 on the next edge and state_dbg=0. On relock the sequence restarts from stage 0 with retry_cnt unchanged.
- Ready drop in RUN:
  - Stimulus: deassert stage_ready[0] for 1 cycle.
  - Required: all_ready=0 and stage_rst=111 next edge; full re-sequence; retry_cnt stays 0.
- Simultaneous events:
  - Ready on the last timeout cycle → stage advances, no retry.
  - soft_rst together with lock loss → IDLE.
- rst_sys_n asserted in RUN:
  - Required: all outputs at their reset values after 1 edge. Sequence restarts only after release and lock.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the ordered reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } reset_seq_state_t;

    localparam int STATE_W = 3;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter that sticks at zero; load has priority over enable.
module reset_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order, waiting for each stage's ready
// flag, with bounded timeout retries and a latched fault.
//
// state | meaning
// IDLE  | waiting for pll lock, all stages held in reset
// HOLD  | counting reset hold before releasing stage k
// WAIT  | stage k released, waiting for its ready (timeout running)
// RUN   | every stage released and ready
// FAULT | retries exhausted, all stages held until soft_rst or reset
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int  NUM_STAGES  = 3,
    parameter int  RELEASE_DLY = 256,
    parameter int  TIMEOUT     = 1048576,
    parameter int  RETRY_MAX   = 3,
    localparam int RETRY_W     = width_of(RETRY_MAX)
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic                  pll_locked,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic                  soft_rst,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  fault,
    output logic [RETRY_W-1:0]    retry_cnt,
    output logic [STATE_W-1:0]    state_dbg
);

    localparam int K_W   = width_of(NUM_STAGES - 1);
    localparam int CNT_W = width_of(RELEASE_DLY - 1);
    localparam int TMO_W = width_of(TIMEOUT - 1);

    localparam logic [K_W-1:0]     K_LAST    = K_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(RELEASE_DLY - 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

    reset_seq_state_t     state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 hold_load, tmo_load;
    logic                 cnt_zero, tmo_zero;
    logic                 ready_k, lower_drop;
    logic [NUM_STAGES-1:0] lower_mask;

    reset_seq_timer #(.WIDTH(CNT_W)) u_hold_timer (
        .clk_i      (clk_sys),
        .rst_n_i    (rst_sys_n),
        .load_i     (hold_load),
        .load_val_i (CNT_LOAD),
        .en_i       (state_q == ST_HOLD),
        .zero_o     (cnt_zero)
    );

    reset_seq_timer #(.WIDTH(TMO_W)) u_tmo_timer (
        .clk_i      (clk_sys),
        .rst_n_i    (rst_sys_n),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .en_i       (state_q == ST_WAIT),
        .zero_o     (tmo_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            retry_q <= retry_d;
        end
    end

    // An already-released stage losing ready is treated like a timeout.
    always_comb begin
        lower_mask = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (j < int'(k_q)) lower_mask[j] = 1'b1;
        end
    end

    assign ready_k    = stage_ready[k_q];
    assign lower_drop = |(lower_mask & ~stage_ready);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        retry_d   = retry_q;
        hold_load = 1'b0;
        tmo_load  = 1'b0;
        if (!pll_locked) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end else if (soft_rst && (state_q != ST_IDLE)) begin
            state_d   = ST_HOLD;
            k_d       = '0;
            retry_d   = '0;
            hold_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_HOLD;
                    k_d       = '0;
                    hold_load = 1'b1;
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state_d  = ST_WAIT;
                        tmo_load = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ready_k) begin
                        if (k_q == K_LAST) begin
                            state_d = ST_RUN;
                            retry_d = '0;
                        end else begin
                            state_d   = ST_HOLD;
                            k_d       = k_q + 1'b1;
                            hold_load = 1'b1;
                        end
                    end else if (tmo_zero || lower_drop) begin
                        if (retry_q < RETRY_LIM) begin
                            state_d   = ST_HOLD;
                            k_d       = '0;
                            retry_d   = retry_q + 1'b1;
                            hold_load = 1'b1;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_RUN: begin
                    if (!(&stage_ready)) begin
                        state_d   = ST_HOLD;
                        k_d       = '0;
                        hold_load = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so inputs never reach them combinationally.
    always_comb begin
        stage_rst = '1;
        for (int j = 0; j < NUM_STAGES; j++) begin
            case (state_q)
                ST_HOLD: stage_rst[j] = (j >= int'(k_q));
                ST_WAIT: stage_rst[j] = (j > int'(k_q));
                ST_RUN:  stage_rst[j] = 1'b0;
                default: stage_rst[j] = 1'b1;
            endcase
        end
        all_ready = (state_q == ST_RUN);
        fault     = (state_q == ST_FAULT);
        retry_cnt = retry_q;
        state_dbg = state_q;
    end

endmodule
